// File: rtl/riscv_step_sequencer_pkg.sv
// Shared state encodings and state-class helpers for the step sequencer.
package riscv_step_sequencer_pkg;

    localparam int SEQ_W = 3;

    typedef enum logic [SEQ_W-1:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_READ   = 3'd3,
        SEQ_EXEC   = 3'd4,
        SEQ_WB     = 3'd5,
        SEQ_HALT   = 3'd6,
        SEQ_ERROR  = 3'd7
    } seq_state_t;

    function automatic logic seq_is_busy(input seq_state_t s);
        return (s != SEQ_IDLE) && (s != SEQ_HALT) && (s != SEQ_ERROR);
    endfunction

    // States that wait on a done handshake and are covered by the timeout.
    function automatic logic seq_is_wait(input seq_state_t s);
        return (s == SEQ_FETCH) || (s == SEQ_DECODE) || (s == SEQ_READ) || (s == SEQ_EXEC);
    endfunction

endpackage

// File: rtl/riscv_step_sequencer_btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; one-cycle pulse per press.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/riscv_step_sequencer.sv
// Multi-cycle core controller: FETCH->DECODE->READ->EXEC->WB per step, with timeout and halt.
// Optional free-run mode (extra `run` input) enabled by defining SEQ_FREERUN_EN.
module riscv_step_sequencer
    import riscv_step_sequencer_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int PC_LIMIT = 1023,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
`ifdef SEQ_FREERUN_EN
    input  logic             run,
`endif
    input  logic [PC_W-1:0]  pc,
    output logic             pc_adv,
    output logic             mem_start,
    input  logic             mem_done,
    output logic             decode_start,
    input  logic             decode_done,
    output logic             read_en,
    input  logic             read_done,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             wb_en,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [PC_W-1:0] LP_PC_LIMIT = PC_W'(PC_LIMIT);
    localparam logic [3:0]      LP_TMO_LAST = 4'(TIMEOUT - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [3:0]       r_tmo;
    logic [CNT_W-1:0] r_retired;
    logic             r_pc_adv;
    logic             r_mem_start;
    logic             r_decode_start;
    logic             r_read_en;
    logic             r_alu_start;
    logic             r_wb_en;
    logic             w_step;
    logic             w_go;
    logic             w_done;
    logic             w_entry;

    btn_sync_edge u_btn_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn),
        .o_pulse (w_step)
    );

`ifdef SEQ_FREERUN_EN
    assign w_go = w_step | run;
`else
    assign w_go = w_step;
`endif

    // Only the owning state listens to its done; strays elsewhere are ignored.
    always_comb begin
        w_done = 1'b0;
        case (r_state)
            SEQ_FETCH:  w_done = mem_done;
            SEQ_DECODE: w_done = decode_done;
            SEQ_READ:   w_done = read_done;
            SEQ_EXEC:   w_done = alu_done;
            default:    w_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A done on the last allowed cycle takes priority over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEQ_IDLE:   if (w_go) w_state_nxt = SEQ_FETCH;
            SEQ_FETCH:  if (w_done) w_state_nxt = SEQ_DECODE;
                        else if (r_tmo == LP_TMO_LAST) w_state_nxt = SEQ_ERROR;
            SEQ_DECODE: if (w_done) w_state_nxt = SEQ_READ;
                        else if (r_tmo == LP_TMO_LAST) w_state_nxt = SEQ_ERROR;
            SEQ_READ:   if (w_done) w_state_nxt = SEQ_EXEC;
                        else if (r_tmo == LP_TMO_LAST) w_state_nxt = SEQ_ERROR;
            SEQ_EXEC:   if (w_done) w_state_nxt = SEQ_WB;
                        else if (r_tmo == LP_TMO_LAST) w_state_nxt = SEQ_ERROR;
            SEQ_WB:     w_state_nxt = (pc == LP_PC_LIMIT) ? SEQ_HALT : SEQ_IDLE;
            default:    w_state_nxt = r_state;
        endcase
    end

    assign w_entry = (w_state_nxt != r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_start    <= 1'b0;
            r_decode_start <= 1'b0;
            r_read_en      <= 1'b0;
            r_alu_start    <= 1'b0;
            r_wb_en        <= 1'b0;
            r_pc_adv       <= 1'b0;
        end else begin
            r_mem_start    <= w_entry && (w_state_nxt == SEQ_FETCH);
            r_decode_start <= w_entry && (w_state_nxt == SEQ_DECODE);
            r_read_en      <= w_entry && (w_state_nxt == SEQ_READ);
            r_alu_start    <= w_entry && (w_state_nxt == SEQ_EXEC);
            r_wb_en        <= w_entry && (w_state_nxt == SEQ_WB);
            r_pc_adv       <= (r_state == SEQ_WB) && (w_state_nxt == SEQ_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= 4'd0;
        end else if (w_entry) begin
            r_tmo <= 4'd0;
        end else if (seq_is_wait(r_state)) begin
            r_tmo <= r_tmo + 4'd1;
        end
    end

    // Retire count wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (r_state == SEQ_WB) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign pc_adv       = r_pc_adv;
    assign mem_start    = r_mem_start;
    assign decode_start = r_decode_start;
    assign read_en      = r_read_en;
    assign alu_start    = r_alu_start;
    assign wb_en        = r_wb_en;
    assign busy         = seq_is_busy(r_state);
    assign halted       = (r_state == SEQ_HALT);
    assign error        = (r_state == SEQ_ERROR);
    assign state        = r_state;
    assign retired      = r_retired;

endmodule

// File: tb/tb_riscv_step_sequencer.sv
// Directed bench for riscv_step_sequencer with a pulse-order scoreboard and latency-programmable responders.
module tb_riscv_step_sequencer;

    logic        clk;
    logic        rst;
    logic        btn;
    logic [9:0]  pc;
    logic        pc_adv, mem_start, decode_start, read_en, alu_start, wb_en;
    logic        mem_done, decode_done, read_done, alu_done;
    logic        busy, halted, error;
    logic [2:0]  state;
    logic [15:0] retired;
`ifdef SEQ_FREERUN_EN
    logic        run;
`endif

    int total = 0;
    int bad   = 0;
    int q[$];
    int lat   = 1;
    logic [3:0] hold  = 4'b0000;
    logic [3:0] stray = 4'b0000;
    int rem[4];
    int mon_n, mon_code;

    riscv_step_sequencer #(
        .PC_W(10), .PC_LIMIT(4), .TIMEOUT(15), .CNT_W(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
`ifdef SEQ_FREERUN_EN
        .run          (run),
`endif
        .pc           (pc),
        .pc_adv       (pc_adv),
        .mem_start    (mem_start),
        .mem_done     (mem_done),
        .decode_start (decode_start),
        .decode_done  (decode_done),
        .read_en      (read_en),
        .read_done    (read_done),
        .alu_start    (alu_start),
        .alu_done     (alu_done),
        .wb_en        (wb_en),
        .busy         (busy),
        .halted       (halted),
        .error        (error),
        .state        (state),
        .retired      (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pulses();
        return {pc_adv, wb_en, alu_start, read_en, decode_start, mem_start};
    endfunction

    task automatic push_seq(input int last);
        for (int c = 1; c <= last; c++) q.push_back(c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(tag, state, s);
    endtask

    task automatic run_instr(input int budget, output int busy_n);
        bit seen = 0;
        busy_n = 0;
        btn = 1'b1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (k == 1) btn = 1'b0;
            if (busy) begin
                seen = 1;
                busy_n++;
            end else if (seen) begin
                break;
            end
        end
        btn = 1'b0;
    endtask

    // Stage responders: done follows its start by `lat` cycles (0 = same cycle).
    initial begin
        logic [3:0] st, dn;
        {alu_done, read_done, decode_done, mem_done} = 4'b0;
        foreach (rem[k]) rem[k] = 0;
        forever begin
            tick();
            st = {alu_start, read_en, decode_start, mem_start};
            dn = 4'b0;
            for (int k = 0; k < 4; k++) begin
                if (rem[k] > 0) begin
                    rem[k]--;
                    if (rem[k] == 0) dn[k] = 1'b1;
                end
                if (st[k]) begin
                    if (lat == 0) dn[k] = 1'b1;
                    else rem[k] = lat;
                end
            end
            if (rst) begin
                foreach (rem[k]) rem[k] = 0;
                dn = 4'b0;
            end
            dn = (dn & ~hold) | stray;
            {alu_done, read_done, decode_done, mem_done} = dn;
        end
    end

    // Pulse monitor: at most one pulse per cycle, in scoreboard order.
    initial begin
        forever begin
            tick();
            mon_n = 0;
            mon_code = 0;
            for (int b = 0; b < 6; b++) begin
                if (pulses()[b]) begin
                    mon_n++;
                    mon_code = b + 1;
                end
            end
            if (mon_n > 0) begin
                chk("pulse_onehot", mon_n, 1);
                if (q.size() == 0) chk("pulse_unexpected", mon_code, 0);
                else chk("pulse_order", mon_code, q.pop_front());
            end
        end
    end

    initial begin
        int bn;
        int n;
        int exp_ret;
        rst = 1'b1;
        btn = 1'b0;
        pc  = 10'd0;
`ifdef SEQ_FREERUN_EN
        run = 1'b0;
`endif
        #2;
        chk("rst_state_async", state, 0);
        do_reset();
        exp_ret = 0;
        chk("rst_state", state, 0);
        chk("rst_pulses", pulses(), 0);
        chk("rst_flags", {busy, halted, error}, 0);
        chk("rst_retired", retired, 0);

        // One instruction, dones one cycle after each start.
        lat = 1;
        push_seq(6);
        run_instr(60, bn);
        exp_ret++;
        chk("lat1_busy_cycles", bn, 9);
        chk("lat1_retired", retired, exp_ret);
        chk("lat1_state", state, 0);
        chk("lat1_queue", q.size(), 0);

        // Zero-wait dones: five busy cycles, six cycles step to IDLE.
        lat = 0;
        push_seq(6);
        run_instr(60, bn);
        exp_ret++;
        chk("lat0_busy_cycles", bn, 5);
        chk("lat0_retired", retired, exp_ret);

        // Stray dones in IDLE do nothing.
        stray = 4'hF;
        repeat (3) tick();
        stray = 4'h0;
        repeat (3) tick();
        chk("stray_state", state, 0);
        chk("stray_retired", retired, exp_ret);

        // Extra presses while busy are dropped.
        lat = 3;
        push_seq(6);
        btn = 1'b1;
        tick();
        tick();
        btn = 1'b0;
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        chk("multi_busy_start", busy, 1);
        repeat (3) begin
            btn = 1'b1;
            tick();
            btn = 1'b0;
            tick();
        end
        chk("multi_still_busy", busy, 1);
        wait_state(3'd0, 40, "multi_back_idle");
        repeat (12) tick();
        exp_ret++;
        chk("multi_retired", retired, exp_ret);
        chk("multi_state", state, 0);
        chk("multi_queue", q.size(), 0);

        // Done on the last allowed cycle beats the timeout.
        lat = 14;
        push_seq(6);
        run_instr(120, bn);
        exp_ret++;
        chk("late_done_busy", bn, 61);
        chk("late_done_error", error, 0);
        chk("late_done_retired", retired, exp_ret);

        // Withheld read_done -> ERROR after 15 cycles in READ.
        lat = 1;
        hold = 4'b0100;
        push_seq(3);
        btn = 1'b1;
        tick();
        tick();
        btn = 1'b0;
        wait_state(3'd3, 20, "tmo_reach_read");
        n = 0;
        while (state === 3'd3 && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_cycles_in_read", n, 15);
        chk("tmo_state", state, 7);
        chk("tmo_flags", {busy, halted, error}, 3'b001);
        btn = 1'b1;
        tick();
        tick();
        btn = 1'b0;
        repeat (8) tick();
        chk("tmo_sticky", state, 7);
        hold = 4'b0000;
        do_reset();
        exp_ret = 0;
        chk("tmo_rst_state", state, 0);
        chk("tmo_rst_error", error, 0);
        chk("tmo_rst_retired", retired, 0);
        chk("tmo_queue", q.size(), 0);

        // PC limit reached at WB -> HALT, no pc_adv.
        pc = 10'd4;
        lat = 0;
        push_seq(5);
        btn = 1'b1;
        tick();
        tick();
        btn = 1'b0;
        wait_state(3'd6, 30, "halt_state");
        exp_ret++;
        chk("halt_flags", {busy, halted, error}, 3'b010);
        chk("halt_retired", retired, exp_ret);
        btn = 1'b1;
        tick();
        tick();
        btn = 1'b0;
        repeat (8) tick();
        chk("halt_sticky", state, 6);
        chk("halt_sticky_retired", retired, exp_ret);
        chk("halt_queue", q.size(), 0);
        pc = 10'd0;
        do_reset();
        exp_ret = 0;
        chk("halt_rst", {halted, state}, 0);

        // Reset during EXEC aborts with no wb_en.
        lat = 1;
        hold = 4'b1000;
        push_seq(4);
        btn = 1'b1;
        tick();
        tick();
        btn = 1'b0;
        wait_state(3'd4, 30, "abort_reach_exec");
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_async_state", state, 0);
        chk("abort_async_pulses", pulses(), 0);
        tick();
        chk("abort_flags", {busy, halted, error}, 0);
        chk("abort_retired", retired, 0);
        rst = 1'b0;
        hold = 4'b0000;
        tick();
        chk("abort_queue", q.size(), 0);
        push_seq(6);
        run_instr(60, bn);
        exp_ret++;
        chk("abort_recover_retired", retired, exp_ret);

`ifdef SEQ_FREERUN_EN
        begin
            int gap = 0;
            int maxgap = 0;
            int base;
            base = exp_ret;
            lat = 0;
            for (int i = 0; i < 10; i++) push_seq(6);
            run = 1'b1;
            for (int k = 0; k < 200; k++) begin
                tick();
                if (state === 3'd0) begin
                    gap++;
                end else begin
                    if (gap > maxgap) maxgap = gap;
                    gap = 0;
                end
                if (run && state === 3'd1 && retired == 16'(base + 9)) run = 1'b0;
                if (!run && state === 3'd0) break;
            end
            run = 1'b0;
            exp_ret = base + 10;
            chk("freerun_retired", retired, exp_ret);
            chk("freerun_gap_ok", (maxgap <= 1), 1);
            repeat (10) tick();
            chk("freerun_stopped", retired, exp_ret);
            chk("freerun_queue", q.size(), 0);
        end
`endif

        repeat (3) tick();
        chk("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
